// File: rtl/cpu_stackctl_pkg.sv
// Shared constants for the CPU stack controller: FSM encodings,
// default geometry and the stack-pointer width helper.
package cpu_stackctl_pkg;

  // Default geometry: 2048 entries of 35 bits; host waits 4 cycles at most.
  localparam int DEPTH_LG_DEF = 11;
  localparam int WIDTH_DEF    = 35;
  localparam int STARVE_DEF   = 4;

  // Controller FSM encodings (kept as plain constants for legacy tools).
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_RDATA = 2'd2;
  localparam logic [1:0] ST_HOST  = 2'd3;

  // The stack pointer counts 0..2**depth_lg inclusive, so it needs one extra bit.
  function automatic int sp_width(input int depth_lg);
    return depth_lg + 1;
  endfunction

endpackage

// File: rtl/cpu_stackctl_arb.sv
// Host / writeback arbiter for the stack RAM. Writeback normally wins;
// the host wins when writeback is idle or once it has waited STARVE cycles.
module cpu_stack_arb
  import cpu_stackctl_pkg::*;
#(
  parameter int STARVE = STARVE_DEF
) (
  input  logic clk,
  input  logic rst_b,
  input  logic i_idle,
  input  logic i_wb_valid,
  input  logic i_host_req,
  output logic o_host_win
);

  localparam int CW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);

  logic [CW-1:0] r_wait_cnt;
  logic          w_starved;

  assign w_starved = (r_wait_cnt >= CW'(STARVE));

  // Grant only from IDLE; gated by reset so no grant can leak while held in reset.
  assign o_host_win = rst_b & i_idle & i_host_req & (~i_wb_valid | w_starved);

  // Starvation counter: counts ungranted request cycles, saturates, clears on grant.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wait_cnt <= '0;
    end else if (o_host_win) begin
      r_wait_cnt <= '0;
    end else if (i_host_req && !w_starved) begin
      r_wait_cnt <= r_wait_cnt + CW'(1);
    end else begin
      r_wait_cnt <= r_wait_cnt;
    end
  end

endmodule

// File: rtl/cpu_stackctl.sv
// CPU stack controller: applies writeback pop/push ops to a RAM-backed
// stack, keeps the top-of-stack cached, refills it after pops, and shares
// the RAM port with a host through cpu_stack_arb.
module cpu_stackctl
  import cpu_stackctl_pkg::*;
#(
  parameter int DEPTH_LG = DEPTH_LG_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int STARVE   = STARVE_DEF
) (
  input  logic                clk,
  input  logic                rst_b,
  // writeback op
  input  logic                wb_valid,
  input  logic                st__push_5a,
  input  logic [DEPTH_LG-1:0] st__to_pop_5a,
  input  logic [WIDTH-1:0]    st__to_push_5a,
  output logic                wb_stall,
  // host port
  input  logic                host_req,
  input  logic                host_we,
  input  logic [DEPTH_LG-1:0] host_addr,
  input  logic [WIDTH-1:0]    host_wdata,
  output logic                host_gnt,
  output logic [WIDTH-1:0]    host_rdata,
  output logic                host_rvalid,
  // stack RAM
  output logic                ram_en,
  output logic                ram_we,
  output logic [DEPTH_LG-1:0] ram_addr,
  output logic [WIDTH-1:0]    ram_wdata,
  input  logic [WIDTH-1:0]    ram_rdata,
  // stack status
  output logic [DEPTH_LG:0]   sp,
  output logic [WIDTH-1:0]    tos,
  output logic                tos_valid,
  output logic                err_underflow,
  output logic                err_overflow,
  input  logic                err_clr
);

  localparam int             SPW     = sp_width(DEPTH_LG);
  localparam logic [SPW-1:0] SP_FULL = {1'b1, {DEPTH_LG{1'b0}}};
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);

  logic [1:0]          r_state;
  logic [SPW-1:0]      r_sp;
  logic [WIDTH-1:0]    r_tos;
  logic                r_tos_valid;
  logic                r_err_uf;
  logic                r_err_of;
  logic                r_host_rd;

  logic                w_idle;
  logic                w_host_win;
  logic                w_accept;
  logic [SPW-1:0]      w_pop_ext;
  logic                w_under;
  logic [SPW-1:0]      w_base;
  logic                w_full;
  logic                w_push_ok;
  logic                w_ovf_ev;
  logic                w_unf_ev;
  logic                w_pop_only;
  logic [DEPTH_LG-1:0] w_sp_m1;
  logic                w_host_tos_hit;

  assign w_idle = (r_state == ST_IDLE);

  cpu_stack_arb #(
    .STARVE (STARVE)
  ) u_arb (
    .clk        (clk),
    .rst_b      (rst_b),
    .i_idle     (w_idle),
    .i_wb_valid (wb_valid),
    .i_host_req (host_req),
    .o_host_win (w_host_win)
  );

  // Writeback is held off outside IDLE and whenever the host takes the port.
  assign wb_stall = ~w_idle | w_host_win;
  assign host_gnt = w_host_win;
  assign w_accept = rst_b & wb_valid & ~wb_stall;

  // Pop first (clamped at empty), then an optional push on top of the base.
  assign w_pop_ext  = {1'b0, st__to_pop_5a};
  assign w_under    = (w_pop_ext > r_sp);
  assign w_base     = w_under ? '0 : (r_sp - w_pop_ext);
  assign w_full     = (w_base == SP_FULL);
  assign w_push_ok  = w_accept & st__push_5a & ~w_full;
  assign w_ovf_ev   = w_accept & st__push_5a & w_full;
  assign w_unf_ev   = w_accept & w_under;
  assign w_pop_only = w_accept & ~st__push_5a & (st__to_pop_5a != '0);

  assign w_sp_m1 = r_sp[DEPTH_LG-1:0] - DEPTH_LG'(1);

  // A host write that lands on the cached top entry must refresh the cache.
  assign w_host_tos_hit = w_host_win & host_we & r_tos_valid &
                          (r_sp != '0) & (host_addr == w_sp_m1);

  // RAM port mux: writeback push, host access, or the refill read in FETCH.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (w_push_ok) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = w_base[DEPTH_LG-1:0];
      ram_wdata = st__to_push_5a;
    end else if (w_host_win) begin
      ram_en    = 1'b1;
      ram_we    = host_we;
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
    end else if (r_state == ST_FETCH) begin
      ram_en    = 1'b1;
      ram_we    = 1'b0;
      ram_addr  = w_sp_m1;
      ram_wdata = '0;
    end else begin
      ram_en    = 1'b0;
    end
  end

  // Controller FSM: refill sequence after a pop, one-cycle host access slot.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_host_win) begin
            r_state <= ST_HOST;
          end else if (w_pop_only && (w_base != '0)) begin
            r_state <= ST_FETCH;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_FETCH: r_state <= ST_RDATA;
        ST_RDATA: r_state <= ST_IDLE;
        ST_HOST:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Stack pointer: a no-op leaves base == sp, an overflowing push leaves it full.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_sp <= '0;
    end else if (w_accept) begin
      r_sp <= w_push_ok ? (w_base + SP_ONE) : w_base;
    end else begin
      r_sp <= r_sp;
    end
  end

  // Top-of-stack cache: set by push, invalidated by pop, refilled in RDATA.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_tos       <= '0;
      r_tos_valid <= 1'b0;
    end else if (w_push_ok) begin
      r_tos       <= st__to_push_5a;
      r_tos_valid <= 1'b1;
    end else if (w_pop_only) begin
      r_tos       <= r_tos;
      r_tos_valid <= 1'b0;
    end else if (r_state == ST_RDATA) begin
      r_tos       <= ram_rdata;
      r_tos_valid <= 1'b1;
    end else if (w_host_tos_hit) begin
      r_tos       <= host_wdata;
      r_tos_valid <= r_tos_valid;
    end else begin
      r_tos       <= r_tos;
      r_tos_valid <= r_tos_valid;
    end
  end

  // Sticky error flags; a new event outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_err_uf <= 1'b0;
      r_err_of <= 1'b0;
    end else begin
      r_err_uf <= w_unf_ev | (r_err_uf & ~err_clr);
      r_err_of <= w_ovf_ev | (r_err_of & ~err_clr);
    end
  end

  // Remember whether the granted host access was a read.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_host_rd <= 1'b0;
    end else if (w_host_win) begin
      r_host_rd <= ~host_we;
    end else begin
      r_host_rd <= r_host_rd;
    end
  end

  assign host_rvalid   = (r_state == ST_HOST) & r_host_rd;
  assign host_rdata    = host_rvalid ? ram_rdata : '0;

  assign sp            = r_sp;
  assign tos           = r_tos;
  assign tos_valid     = r_tos_valid;
  assign err_underflow = r_err_uf;
  assign err_overflow  = r_err_of;

endmodule

// File: tb/tb_cpu_stackctl.sv
// Bench for cpu_stackctl: a RAM model, a stack-level reference model,
// a per-cycle compare process and directed scenarios with literal checks.
module tb_cpu_stackctl;

  localparam int DL   = 11;
  localparam int W    = 35;
  localparam int ST   = 4;
  localparam int FULL = 2048;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          wb_valid, push, host_req, host_we, err_clr;
  logic [DL-1:0] pop, host_addr;
  logic [W-1:0]  pdata, host_wdata;
  logic          wb_stall, host_gnt, host_rvalid, ram_en, ram_we, tos_valid;
  logic          err_underflow, err_overflow;
  logic [W-1:0]  host_rdata, ram_wdata, ram_rdata, tos;
  logic [DL-1:0] ram_addr;
  logic [DL:0]   sp;

  logic [W-1:0]  mem [0:FULL-1];

  always #5 clk = ~clk;

  cpu_stackctl #(.DEPTH_LG(DL), .WIDTH(W), .STARVE(ST)) dut (
    .clk(clk), .rst_b(rst_b),
    .wb_valid(wb_valid), .st__push_5a(push), .st__to_pop_5a(pop),
    .st__to_push_5a(pdata), .wb_stall(wb_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .sp(sp), .tos(tos), .tos_valid(tos_valid),
    .err_underflow(err_underflow), .err_overflow(err_overflow), .err_clr(err_clr)
  );

  // Synchronous RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: stack contents as an array plus a few status values.
  int           m_sp, m_hcnt, m_reload, m_haddr;
  logic [W-1:0] m_tos;
  bit           m_tosv, m_uf, m_of, m_inhost, m_hrd;
  logic [W-1:0] m_mem [0:FULL-1];

  bit           e_stall, e_gnt, e_rvalid, e_en, e_we, e_accept, e_win;
  bit           e_pushok, e_unf;
  int           e_addr, e_base;
  logic [W-1:0] e_wdata, e_rdata;
  bit           chk_on = 1'b0;

  task automatic model_reset();
    m_sp = 0; m_hcnt = 0; m_reload = 0; m_haddr = 0; m_tos = '0;
    m_tosv = 0; m_uf = 0; m_of = 0; m_inhost = 0; m_hrd = 0;
  endtask

  // What the outputs must be this cycle, from model state and current inputs.
  task automatic calc();
    int  p;
    bit  idle;
    p        = int'(pop);
    idle     = (m_reload == 0) && !m_inhost;
    e_win    = idle && host_req && (!wb_valid || m_hcnt >= ST);
    e_stall  = !idle || e_win;
    e_gnt    = e_win;
    e_accept = wb_valid && !e_stall;
    e_unf    = e_accept && (p > m_sp);
    e_base   = (p > m_sp) ? 0 : m_sp - p;
    e_pushok = e_accept && push && (e_base < FULL);
    e_rvalid = m_inhost && m_hrd;
    e_rdata  = m_mem[m_haddr];
    e_en = 0; e_we = 0; e_addr = 0; e_wdata = '0;
    if (e_pushok) begin
      e_en = 1; e_we = 1; e_addr = e_base; e_wdata = pdata;
    end else if (e_win) begin
      e_en = 1; e_we = host_we; e_addr = int'(host_addr); e_wdata = host_wdata;
    end else if (m_reload == 2) begin
      e_en = 1; e_addr = m_sp - 1;
    end
  endtask

  // Advance the model across one clock edge.
  task automatic update();
    if (m_reload == 1) begin
      m_tos = m_mem[m_sp-1]; m_tosv = 1;
    end
    if (m_reload > 0) m_reload--;
    if (e_pushok) begin
      m_mem[e_base] = pdata; m_sp = e_base + 1; m_tos = pdata; m_tosv = 1;
    end else if (e_accept && !push && pop != 0) begin
      m_sp = e_base; m_tosv = 0; m_reload = (e_base > 0) ? 2 : 0;
    end
    if (e_win) begin
      m_hrd = !host_we; m_haddr = int'(host_addr);
      if (host_we) begin
        m_mem[host_addr] = host_wdata;
        if (m_tosv && m_sp > 0 && int'(host_addr) == m_sp - 1) m_tos = host_wdata;
      end
    end
    m_inhost = e_win;
    m_uf = e_unf ? 1'b1 : (err_clr ? 1'b0 : m_uf);
    m_of = (e_accept && push && e_base == FULL) ? 1'b1 : (err_clr ? 1'b0 : m_of);
    if (e_win) m_hcnt = 0;
    else if (host_req && m_hcnt < ST) m_hcnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    update();
    #1;
    calc();
  endtask

  task automatic drive(input bit v, input bit pu, input int pp, input logic [W-1:0] pd,
                       input bit hr, input bit hw, input int ha, input logic [W-1:0] hd,
                       input bit clr);
    wb_valid = v; push = pu; pop = DL'(pp); pdata = pd;
    host_req = hr; host_we = hw; host_addr = DL'(ha); host_wdata = hd; err_clr = clr;
    calc();
  endtask

  task automatic idle_in();
    drive(0, 0, 0, '0, 0, 0, 0, '0, 0);
  endtask

  task automatic rst_pulse();
    rst_b = 1'b0;
    idle_in();
    model_reset();
    #1;
    chk("rst_mid_rvalid", host_rvalid, 0);
    chk("rst_mid_sp", sp, 0);
    chk("rst_mid_tos_valid", tos_valid, 0);
    chk("rst_mid_ram_en", ram_en, 0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    calc();
  endtask

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge clk) begin
    if (chk_on && rst_b) begin
      chk("sp", sp, m_sp);
      chk("tos_valid", tos_valid, m_tosv);
      if (m_tosv) chk("tos", tos, m_tos);
      chk("err_underflow", err_underflow, m_uf);
      chk("err_overflow", err_overflow, m_of);
      chk("wb_stall", wb_stall, e_stall);
      chk("host_gnt", host_gnt, e_gnt);
      chk("host_rvalid", host_rvalid, e_rvalid);
      if (e_rvalid) chk("host_rdata", host_rdata, e_rdata);
      chk("ram_en", ram_en, e_en);
      if (e_en) begin
        chk("ram_we", ram_we, e_we);
        chk("ram_addr", ram_addr, e_addr);
        if (e_we) chk("ram_wdata", ram_wdata, e_wdata);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int got;
    bit stl;
    rst_b = 1'b0;
    model_reset();
    // Requests present during reset must not leak through.
    drive(1, 1, 0, 35'h3, 1, 0, 0, '0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sp", sp, 0);
    chk("rst_tos_valid", tos_valid, 0);
    chk("rst_wb_stall", wb_stall, 0);
    chk("rst_host_gnt", host_gnt, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_err", {err_underflow, err_overflow}, 0);
    idle_in();
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    calc();
    chk_on = 1'b1;

    // Two back-to-back pushes.
    drive(1, 1, 0, 35'h1, 0, 0, 0, '0, 0); #1 chk("push1_stall", wb_stall, 0); tick();
    drive(1, 1, 0, 35'h2, 0, 0, 0, '0, 0); #1 chk("push2_stall", wb_stall, 0); tick();
    idle_in();
    chk("push_sp", sp, 2);
    chk("push_tos", tos, 35'h2);
    chk("push_mem0", mem[0], 35'h1);
    chk("push_mem1", mem[1], 35'h2);

    // Host read of address 0.
    drive(0, 0, 0, '0, 1, 0, 0, '0, 0); #1 chk("hrd_gnt", host_gnt, 1); tick();
    idle_in(); #1;
    chk("hrd_rvalid", host_rvalid, 1);
    chk("hrd_rdata", host_rdata, 35'h1);
    tick();

    // Host write onto the cached top entry.
    drive(0, 0, 0, '0, 1, 1, 1, 35'h55, 0); tick();
    idle_in();
    chk("hwr_tos", tos, 35'h55);
    tick();

    // Pop one: two stall cycles, then refilled top.
    drive(1, 0, 1, '0, 0, 0, 0, '0, 0); tick();
    idle_in(); #1 chk("pop_stall1", wb_stall, 1); tick();
    #1 chk("pop_stall2", wb_stall, 1); tick();
    #1;
    chk("pop_stall_done", wb_stall, 0);
    chk("pop_tos", tos, 35'h1);
    chk("pop_tos_valid", tos_valid, 1);
    chk("pop_sp", sp, 1);

    // Underflow with a push still executing.
    drive(1, 1, 3, 35'h7, 0, 0, 0, '0, 0); tick();
    idle_in();
    chk("unf_flag", err_underflow, 1);
    chk("unf_sp", sp, 1);
    chk("unf_tos", tos, 35'h7);
    tick();
    chk("unf_mem0", mem[0], 35'h7);

    // Clear, then underflow coinciding with clear keeps the flag.
    drive(0, 0, 0, '0, 0, 0, 0, '0, 1); tick();
    chk("clr_unf", err_underflow, 0);
    drive(1, 0, 5, '0, 0, 0, 0, '0, 1); tick();
    chk("unf_vs_clr", err_underflow, 1);
    chk("unf_empty_sp", sp, 0);
    drive(0, 0, 0, '0, 0, 0, 0, '0, 1); tick();
    idle_in();

    // Host starvation under continuous writeback no-ops.
    got = 0; stl = 0;
    for (int i = 1; i <= 8 && got == 0; i++) begin
      drive(1, 0, 0, '0, 1, 0, 0, '0, 0);
      #1;
      if (host_gnt) begin got = i; stl = wb_stall; end
      tick();
    end
    chk("starve_gnt_cycle", got, 5);
    chk("starve_stall", stl, 1);
    idle_in(); tick();

    // Reset during HOST: no read-valid may appear.
    drive(1, 1, 0, 35'hA, 0, 0, 0, '0, 0); tick();
    drive(0, 0, 0, '0, 1, 0, 0, '0, 0); tick();
    rst_pulse();
    tick();
    chk("post_rst_rvalid", host_rvalid, 0);

    // Reset during FETCH: refill abandoned.
    drive(1, 1, 0, 35'hB, 0, 0, 0, '0, 0); tick();
    drive(1, 1, 0, 35'hC, 0, 0, 0, '0, 0); tick();
    drive(1, 0, 1, '0, 0, 0, 0, '0, 0); tick();
    rst_pulse();
    tick(); tick();
    chk("fetch_rst_tos_valid", tos_valid, 0);

    // Fill to capacity, then overflow.
    for (int i = 0; i < FULL; i++) begin
      drive(1, 1, 0, 35'(i + 100), 0, 0, 0, '0, 0);
      tick();
    end
    idle_in();
    chk("full_sp", sp, FULL);
    drive(1, 1, 0, 35'h5, 0, 0, 0, '0, 0);
    #1 chk("ovf_ram_we", ram_we, 0);
    tick();
    idle_in();
    chk("ovf_flag", err_overflow, 1);
    chk("ovf_sp", sp, FULL);
    drive(1, 1, 0, 35'h9, 0, 0, 0, '0, 1); tick();
    chk("ovf_vs_clr", err_overflow, 1);
    drive(0, 0, 0, '0, 0, 0, 0, '0, 1); tick();
    chk("clr_ovf", err_overflow, 0);

    // Deep pop refills from the array.
    drive(1, 0, 3, '0, 0, 0, 0, '0, 0); tick();
    idle_in(); tick(); tick();
    chk("deep_pop_sp", sp, FULL - 3);
    chk("deep_pop_tos", tos, 35'(2044 + 100));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
